// File: rtl/vpu_operand_stager.sv
// Multi-channel operand stager: per-channel SRAM word streams land in credit-guarded
// FIFOs and are drained in lockstep as EXEC_DW-wide slices of each word.
module vpu_operand_stager #(
    parameter int unsigned CH_CNT     = 3,
    parameter int unsigned SRAM_DW    = 256,
    parameter int unsigned EXEC_DW    = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 10,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [CH_CNT-1:0]           chan_en_i,
    input  logic [CH_CNT*AW-1:0]        base_addr_i,
    input  logic [LEN_W-1:0]            len_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CH_CNT-1:0]           sram_req_o,
    output logic [CH_CNT*AW-1:0]        sram_addr_o,
    input  logic [CH_CNT-1:0]           sram_ack_i,
    input  logic [CH_CNT-1:0]           sram_rvalid_i,
    input  logic [CH_CNT*SRAM_DW-1:0]   sram_rdata_i,
    output logic                        operand_valid_o,
    input  logic                        rden_i,
    output logic [CH_CNT*EXEC_DW-1:0]   operand_rdata_o
);

    localparam int unsigned RATIO = SRAM_DW / EXEC_DW;
    localparam int unsigned SL_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state_q, state_d;

    logic [CH_CNT-1:0]  en_q;
    logic [LEN_W-1:0]   len_q;
    logic [AW-1:0]      base_q   [CH_CNT];
    logic [LEN_W-1:0]   issued_q [CH_CNT];
    logic [CNT_W-1:0]   outst_q  [CH_CNT];
    logic [CNT_W-1:0]   count_q  [CH_CNT];
    logic [PTR_W-1:0]   wptr_q   [CH_CNT];
    logic [PTR_W-1:0]   rptr_q   [CH_CNT];
    logic [SRAM_DW-1:0] mem_q    [CH_CNT][FIFO_DEPTH];
    logic [SL_W-1:0]    slice_q;

    logic [CH_CNT-1:0]  credit_ok, push, hs, pop_ch, not_empty, drained;
    logic               start_acc, consume, last_slice, pop, all_drained;

    assign start_acc  = start_i && (state_q != RUN);
    assign consume    = rden_i && operand_valid_o;
    assign last_slice = (slice_q == SL_W'(RATIO - 1));
    assign pop        = consume && last_slice;

    // Outstanding reads plus buffered words never exceed the FIFO depth, so rvalid
    // can always be accepted without backpressure.
    always_comb begin
        sram_req_o  = '0;
        sram_addr_o = '0;
        credit_ok   = '0;
        push        = '0;
        hs          = '0;
        pop_ch      = '0;
        not_empty   = '0;
        drained     = '0;
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            credit_ok[c] = (SUM_W'(outst_q[c]) + SUM_W'(count_q[c])) < SUM_W'(FIFO_DEPTH);
            sram_req_o[c] = (state_q == RUN) && en_q[c] && (issued_q[c] < len_q) && credit_ok[c];
            sram_addr_o[c*AW +: AW] = base_q[c] + AW'(issued_q[c]);
            hs[c]        = sram_req_o[c] && sram_ack_i[c];
            push[c]      = sram_rvalid_i[c] && (outst_q[c] != '0);
            pop_ch[c]    = pop && en_q[c];
            not_empty[c] = (count_q[c] != '0);
            drained[c]   = (issued_q[c] == len_q) && (outst_q[c] == '0) && (count_q[c] == '0);
        end
    end

    assign all_drained = ((drained | ~en_q) == '1);

    always_comb begin
        operand_valid_o = (en_q != '0) && ((not_empty | ~en_q) == '1);
        operand_rdata_o = '0;
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            if (en_q[c])
                operand_rdata_o[c*EXEC_DW +: EXEC_DW] =
                    mem_q[c][rptr_q[c]][int'(slice_q)*EXEC_DW +: EXEC_DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FINISH: begin
                if (start_i) state_d = ((len_i == '0) || (chan_en_i == '0)) ? FINISH : RUN;
                else         state_d = IDLE;
            end
            RUN:     if (all_drained && (slice_q == '0)) state_d = FINISH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= '0;
            len_q   <= '0;
            slice_q <= '0;
            for (int unsigned c = 0; c < CH_CNT; c++) begin
                base_q[c]   <= '0;
                issued_q[c] <= '0;
                outst_q[c]  <= '0;
                count_q[c]  <= '0;
                wptr_q[c]   <= '0;
                rptr_q[c]   <= '0;
            end
        end else if (start_acc) begin
            en_q    <= chan_en_i;
            len_q   <= len_i;
            slice_q <= '0;
            for (int unsigned c = 0; c < CH_CNT; c++) begin
                base_q[c]   <= base_addr_i[c*AW +: AW];
                issued_q[c] <= '0;
                outst_q[c]  <= '0;
                count_q[c]  <= '0;
                wptr_q[c]   <= '0;
                rptr_q[c]   <= '0;
            end
        end else begin
            if (consume) slice_q <= last_slice ? '0 : slice_q + 1'b1;
            for (int unsigned c = 0; c < CH_CNT; c++) begin
                if (hs[c]) issued_q[c] <= issued_q[c] + 1'b1;
                outst_q[c] <= outst_q[c] + CNT_W'(hs[c]) - CNT_W'(push[c]);
                count_q[c] <= count_q[c] + CNT_W'(push[c]) - CNT_W'(pop_ch[c]);
                if (push[c])   wptr_q[c] <= wptr_q[c] + 1'b1;
                if (pop_ch[c]) rptr_q[c] <= rptr_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            if (push[c]) mem_q[c][wptr_q[c]] <= sram_rdata_i[c*SRAM_DW +: SRAM_DW];
        end
    end

    // Read data with nothing outstanding is a protocol violation by the SRAM side.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            if (rst_n && (state_q == RUN) && sram_rvalid_i[c])
                assert (outst_q[c] != '0);
        end
    end

endmodule
